// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage: operand and opcode widths,
// opcode encodings, the queued command record and small result-flag helpers.
package alu_pkg;

    localparam int DATA_W = 4;
    localparam int OP_W   = 3;

    localparam logic [OP_W-1:0] OP_ADD         = 3'b000;
    localparam logic [OP_W-1:0] OP_SUB         = 3'b001;
    localparam logic [OP_W-1:0] OP_AND         = 3'b010;
    localparam logic [OP_W-1:0] OP_OR          = 3'b011;
    localparam logic [OP_W-1:0] OP_XOR         = 3'b100;
    localparam logic [OP_W-1:0] OP_ILLEGAL_MIN = 3'b101;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        logic [OP_W-1:0]   op;
    } alu_cmd_t;

    localparam alu_cmd_t CMD_NONE = '{a: 4'h0, b: 4'h0, op: 3'b000};

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op >= OP_ILLEGAL_MIN);
    endfunction

    function automatic logic result_is_zero(input logic [DATA_W-1:0] r);
        return (r == 4'h0);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// Bundles the upstream command handshake, the external ALU hookup and the result
// handshake of the issue stage; slave is the stage's view, master the environment's.
interface alu_issue_stage_if;
    import alu_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_a;
    logic [DATA_W-1:0] in_b;
    logic [OP_W-1:0]   in_op;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic [OP_W-1:0]   out_op;
    logic              out_zero;
    logic              out_illegal;

    modport slave (
        input  in_valid, in_a, in_b, in_op, alu_result, out_ready,
        output in_ready, alu_a, alu_b, alu_op,
               out_valid, out_result, out_op, out_zero, out_illegal
    );

    modport master (
        output in_valid, in_a, in_b, in_op, alu_result, out_ready,
        input  in_ready, alu_a, alu_b, alu_op,
               out_valid, out_result, out_op, out_zero, out_illegal
    );

endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO with occupancy counter and a head port that reads as
// all-zero while empty; push/pop are internally qualified by full/empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     push,
    input  logic     pop,
    input  alu_cmd_t wdata,
    output logic     full,
    output logic     empty,
    output alu_cmd_t head
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    alu_cmd_t         mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;

    // Storage write; contents are deliberately left uninitialised by reset.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1'b1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1'b1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1'b1);
                2'b01:   count_r <= count_r - CNT_W'(1'b1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Head presentation, forced to zero so the ALU sees a quiet input when idle.
    always_comb begin
        head = CMD_NONE;
        if (empty) begin
            head = CMD_NONE;
        end else begin
            head = mem_r[rd_ptr_r];
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: queues operand/opcode commands, presents the FIFO head to an external
// combinational ALU and captures its result into a registered valid/ready output slot.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input logic              clk,
    input logic              rst_n,
    alu_issue_stage_if.slave bus
);

    logic              fifo_full_s;
    logic              fifo_empty_s;
    alu_cmd_t          head_s;
    alu_cmd_t          wdata_s;
    logic              push_s;
    logic              issue_s;

    logic              out_valid_r;
    logic [DATA_W-1:0] out_result_r;
    logic [OP_W-1:0]   out_op_r;
    logic              out_zero_r;
    logic              out_illegal_r;

    // Acceptance never depends on a same-cycle pop, so a full queue always stalls upstream.
    assign bus.in_ready = rst_n & ~fifo_full_s;
    assign push_s       = bus.in_valid & bus.in_ready;
    assign issue_s      = ~fifo_empty_s & (~out_valid_r | bus.out_ready);
    assign wdata_s      = '{a: bus.in_a, b: bus.in_b, op: bus.in_op};

    alu_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .pop   (issue_s),
        .wdata (wdata_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .head  (head_s)
    );

    assign bus.alu_a  = head_s.a;
    assign bus.alu_b  = head_s.b;
    assign bus.alu_op = head_s.op;

    // Output slot: capture on issue, drain when consumed with nothing queued, else hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r   <= 1'b0;
            out_result_r  <= 4'h0;
            out_op_r      <= 3'b000;
            out_zero_r    <= 1'b1;
            out_illegal_r <= 1'b0;
        end else if (issue_s) begin
            out_valid_r   <= 1'b1;
            out_result_r  <= bus.alu_result;
            out_op_r      <= head_s.op;
            out_zero_r    <= result_is_zero(bus.alu_result);
            out_illegal_r <= op_is_illegal(head_s.op);
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r   <= 1'b0;
        end else begin
            out_valid_r   <= out_valid_r;
        end
    end

    assign bus.out_valid   = out_valid_r;
    assign bus.out_result  = out_result_r;
    assign bus.out_op      = out_op_r;
    assign bus.out_zero    = out_zero_r;
    assign bus.out_illegal = out_illegal_r;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Randomised and directed bench for alu_issue_stage against a queue-based
// transaction model of the command FIFO and the single output slot.
module tb_alu_issue_stage;
    import alu_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        int a;
        int b;
        int op;
    } cmd_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    alu_issue_stage_if bus ();

    alu_issue_stage #(
        .DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    cmd_t fq[$];
    bit   sv;
    int   sres;
    int   sop;
    bit   acc_last;
    int   hs_cnt;
    int   total = 0;
    int   bad   = 0;

    function automatic int alu_ref(input int a, input int b, input int op);
        case (op)
            0:       return (a + b) % 16;
            1:       return (a - b + 16) % 16;
            2:       return a & b;
            3:       return a | b;
            4:       return a ^ b;
            default: return 0;
        endcase
    endfunction

    // External combinational ALU attached to the stage.
    always_comb bus.alu_result = 4'(alu_ref(int'(bus.alu_a), int'(bus.alu_b), int'(bus.alu_op)));

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit v, input int a, input int b, input int op);
        bus.in_valid = v;
        bus.in_a     = 4'(a);
        bus.in_b     = 4'(b);
        bus.in_op    = 3'(op);
    endtask

    task automatic tick();
        bit   acc;
        cmd_t c;
        int   hexp;
        @(posedge clk);
        acc = 1'b0;
        if (!rst_n) begin
            fq.delete();
            sv   = 1'b0;
            sres = 0;
            sop  = 0;
        end else begin
            acc = bus.in_valid && (fq.size() < DEPTH);
            if (sv && bus.out_ready) hs_cnt++;
            if (fq.size() > 0 && (!sv || bus.out_ready)) begin
                c    = fq.pop_front();
                sv   = 1'b1;
                sres = alu_ref(c.a, c.b, c.op);
                sop  = c.op;
            end else if (sv && bus.out_ready) begin
                sv = 1'b0;
            end
            if (acc) fq.push_back('{int'(bus.in_a), int'(bus.in_b), int'(bus.in_op)});
        end
        acc_last = acc;
        #1;
        hexp = (fq.size() > 0) ? (fq[0].a * 128 + fq[0].b * 8 + fq[0].op) : 0;
        check_eq("out_valid", bus.out_valid, sv);
        check_eq("out_result", bus.out_result, sres);
        check_eq("out_op", bus.out_op, sop);
        check_eq("out_zero", bus.out_zero, sres == 0);
        check_eq("out_illegal", bus.out_illegal, sop >= 5);
        check_eq("in_ready", bus.in_ready, rst_n && (fq.size() < DEPTH));
        check_eq("alu_head", {bus.alu_a, bus.alu_b, bus.alu_op}, hexp);
    endtask

    task automatic send_one(input int a, input int b, input int op);
        drive(1'b1, a, b, op);
        tick();
        drive(1'b0, 0, 0, 0);
        tick();
    endtask

    initial begin
        int k;
        int run;
        int start;
        hs_cnt = 0;
        drive(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        tick();
        tick();
        check_eq("rst_zero", bus.out_zero, 1);
        rst_n = 1'b1;
        tick();

        // Single add: one edge of latency after acceptance.
        drive(1'b1, 3, 5, 0);
        tick();
        check_eq("add_latency", bus.out_valid, 0);
        drive(1'b0, 0, 0, 0);
        tick();
        check_eq("add_valid", bus.out_valid, 1);
        check_eq("add_result", bus.out_result, 8);
        check_eq("add_zero", bus.out_zero, 0);
        tick();

        send_one(2, 3, 1);
        check_eq("sub_wrap", bus.out_result, 15);
        check_eq("sub_op", bus.out_op, 1);
        tick();
        send_one(5, 5, 4);
        check_eq("xor_result", bus.out_result, 0);
        check_eq("xor_zero", bus.out_zero, 1);
        tick();
        send_one(9, 6, 7);
        check_eq("ill_result", bus.out_result, 0);
        check_eq("ill_flag", bus.out_illegal, 1);
        tick();

        // Backpressure: queue fills, then drains in order with nothing lost.
        bus.out_ready = 1'b0;
        k = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, k + 1, 2, k % 5);
            tick();
            if (acc_last) k++;
        end
        check_eq("fill_count", k, 5);
        check_eq("fill_ready", bus.in_ready, 0);
        drive(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        start = hs_cnt;
        repeat (8) tick();
        check_eq("drain_count", hs_cnt - start, 5);

        // Back-to-back stream yields an unbroken run of results.
        run = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, i, i + 3, i % 5);
            tick();
            if (bus.out_valid) run++;
        end
        drive(1'b0, 0, 0, 0);
        repeat (4) begin
            tick();
            if (bus.out_valid) run++;
        end
        check_eq("b2b_run", run, 8);

        // Reset with work queued and a result pending.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, i + 1, 1, 0);
            tick();
        end
        drive(1'b0, 0, 0, 0);
        tick();
        check_eq("pre_rst_valid", bus.out_valid, 1);
        rst_n = 1'b0;
        tick();
        check_eq("rst_valid", bus.out_valid, 0);
        check_eq("rst_ready", bus.in_ready, 0);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        check_eq("post_rst_ready", bus.in_ready, 1);
        send_one(6, 7, 3);
        check_eq("post_rst_result", bus.out_result, 7);

        // Random traffic with occasional resets.
        repeat (400) begin
            rst_n = ($urandom_range(0, 63) != 0);
            drive(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                  int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        rst_n = 1'b1;
        drive(1'b0, 0, 0, 0);
        bus.out_ready = 1'b1;
        repeat (10) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth (power of two, 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  upstream command valid.
REQ-005 in_ready  output  1  stage can accept a command this cycle.
REQ-006 in_a  input  4  operand A.
REQ-007 in_b  input  4  operand B.
REQ-008 in_op  input  3  operation code.
REQ-009 alu_a  output  4  operand A driven to downstream combinational ALU.
REQ-010 alu_b  output  4  operand B driven to ALU.
REQ-011 alu_op  output  3  opcode driven to ALU.
REQ-012 alu_result  input  4  combinational 4-bit result returned by ALU.
REQ-013 out_valid  output  1  registered result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 out_result  output  4  captured ALU result.
REQ-016 out_op  output  3  opcode that produced out_result.
REQ-017 out_zero  output  1  out_result == 0.
REQ-018 out_illegal  output  1  out_op >= 3'b101 (ALU returns 0 for these).

Function
REQ-019 Command accepted on edge where in_valid && in_ready; {in_a,in_b,in_op} written to FIFO tail.
REQ-020 in_ready SHALL be !full, independent of same-cycle pop (no full-bypass).
REQ-021 FIFO occupancy counter 0..DEPTH; read/write pointers wrap modulo DEPTH.
REQ-022 alu_a/alu_b/alu_op SHALL combinationally reflect FIFO head when non-empty; all-zero when empty.
REQ-023 Issue condition: FIFO non-empty && (!out_valid || out_ready).
REQ-024 On issue: out_result<=alu_result, out_op<=head op, out_zero/out_illegal computed from captured values, out_valid<=1, head popped.
REQ-025 If out_valid && out_ready && FIFO empty: out_valid<=0; out_result/out_op hold last values.
REQ-026 If out_valid && !out_ready: output registers and FIFO head SHALL hold stable.
REQ-027 Simultaneous push and pop: counter unchanged, both pointers advance.
REQ-028 No empty-FIFO bypass: command accepted at edge N appears on out_valid at edge N+1 earliest (latency 2 edges from in_valid presentation to capture).
REQ-029 Sustained throughput one result per cycle while out_ready held high and FIFO non-empty.
REQ-030 Commands SHALL exit in acceptance order; none dropped or duplicated.

Reset
REQ-031 While rst_n low at clock edge: counter=0, pointers=0, out_valid=0, out_result=0, out_op=0, out_zero=1, out_illegal=0.
REQ-032 During reset in_ready SHALL be driven 0; FIFO contents need not be cleared.
REQ-033 Reset mid-operation SHALL discard all queued and pending results; first post-reset accepted command is first out.

Structure
REQ-034 Shared package alu_pkg: opcode width (3), data width (4), opcode constants ADD=000, SUB=001, AND=010, OR=011, XOR=100, and command struct typedef {a,b,op}.
REQ-035 One sub-module alu_cmd_fifo (DEPTH-parameterised sync FIFO, full/empty/head outputs); ALU itself remains external.

Verification
REQ-036 Single command A=3,B=5,OP=000 into idle stage, out_ready=1 -> out_valid one edge after accept, out_result=8, out_zero=0.
REQ-037 A=2,B=3,OP=001 -> out_result=15 (wrap), out_op=001; A=5,B=5,OP=100 -> out_result=0, out_zero=1.
REQ-038 out_ready=0, push 5 commands -> in_ready low after 4th accept plus output slot filled; release out_ready -> results in order, none lost.
REQ-039 OP=111, A=9,B=6 -> out_result=0, out_illegal=1.
REQ-040 Back-to-back 8 commands with out_ready=1 -> 8 consecutive out_valid cycles, correct order.
REQ-041 Assert rst_n=0 with 3 queued and out_valid=1 -> next edge out_valid=0, counter 0; subsequent command output correctly.
